// File: rtl/ref_word_fetch.sv
// Producer side of the reference-pixel buffer: walks the frame in strip order,
// issues credit-limited word reads and prefetches responses into a small FIFO.
module ref_word_fetch #(
    parameter int ADDR_W      = 20,
    parameter int LINE_STRIDE = 482,
    parameter int STRIP_WORDS = 482,
    parameter int STRIP_ROWS  = 23,
    parameter int ROW_STEP    = 16,
    parameter int NUM_STRIPS  = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [63:0]       i_mem_rdata,
    input  logic              i_read_en,
    output logic [63:0]       o_ref_data,
    output logic              o_strip_done,
    output logic              o_underflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int ROW_W = (STRIP_ROWS  > 1) ? $clog2(STRIP_ROWS)  : 1;
    localparam int BLK_W = (STRIP_WORDS > 1) ? $clog2(STRIP_WORDS) : 1;
    localparam int STR_W = (NUM_STRIPS  > 1) ? $clog2(NUM_STRIPS)  : 1;
    localparam int POP_W = (STRIP_WORDS * STRIP_ROWS > 1) ? $clog2(STRIP_WORDS * STRIP_ROWS) : 1;
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(LINE_STRIDE);
    localparam logic [ADDR_W-1:0] STRIP_STEP = ADDR_W'(ROW_STEP * LINE_STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr, r_blk_start, r_strip_start;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [BLK_W-1:0]   r_blk_cnt;
    logic [STR_W-1:0]   r_strip_cnt;
    logic [CNT_W-1:0]   r_outstanding, r_count;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [POP_W-1:0]   r_pop_cnt;
    logic               r_strip_done, r_underflow;
    logic [63:0]        r_fifo [FIFO_DEPTH];

    logic               w_start_acc, w_fire, w_last_req, w_push, w_pop, w_empty;
    logic               w_last_row, w_last_blk, w_last_strip, w_last_pop, w_credit_ok;
    logic [CNT_W-1:0]   w_out_nxt, w_count_nxt;

    assign w_start_acc  = i_start && (r_state == S_IDLE);
    assign w_fire       = r_mem_req && i_mem_gnt;
    assign w_last_row   = (r_row_cnt   == ROW_W'(STRIP_ROWS - 1));
    assign w_last_blk   = (r_blk_cnt   == BLK_W'(STRIP_WORDS - 1));
    assign w_last_strip = (r_strip_cnt == STR_W'(NUM_STRIPS - 1));
    assign w_last_req   = w_fire && w_last_row && w_last_blk && w_last_strip;
    assign w_empty      = (r_count == '0);
    assign w_push       = i_mem_rvalid && (r_state != S_IDLE);
    assign w_pop        = i_read_en && !w_empty;
    assign w_last_pop   = (r_pop_cnt == POP_W'(STRIP_WORDS * STRIP_ROWS - 1));
    assign w_out_nxt    = r_outstanding + CNT_W'(w_fire) - CNT_W'(w_push);
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Credits judged on next-cycle occupancy so the registered request never overcommits.
    assign w_credit_ok  = (SUM_W'(w_out_nxt) + SUM_W'(w_count_nxt)) < SUM_W'(FIFO_DEPTH);

    assign o_busy       = (r_state != S_IDLE);
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_ref_data   = w_empty ? '0 : r_fifo[r_rd_ptr];
    assign o_strip_done = r_strip_done;
    assign o_underflow  = r_underflow;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_last_req) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_outstanding == '0 && w_empty) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address walk: row pointer steps by a line, block/strip starts are kept so
    // the next column or strip is one addition away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_blk_start   <= '0;
            r_strip_start <= '0;
            r_row_cnt     <= '0;
            r_blk_cnt     <= '0;
            r_strip_cnt   <= '0;
        end else begin
            r_mem_req <= (w_state_nxt == S_FETCH) && w_credit_ok;
            if (w_start_acc) begin
                r_mem_addr    <= i_base_addr;
                r_blk_start   <= i_base_addr;
                r_strip_start <= i_base_addr;
                r_row_cnt     <= '0;
                r_blk_cnt     <= '0;
                r_strip_cnt   <= '0;
            end else if (w_fire) begin
                if (!w_last_row) begin
                    r_row_cnt  <= r_row_cnt + ROW_W'(1);
                    r_mem_addr <= r_mem_addr + STRIDE;
                end else if (!w_last_blk) begin
                    r_row_cnt   <= '0;
                    r_blk_cnt   <= r_blk_cnt + BLK_W'(1);
                    r_blk_start <= r_blk_start + ADDR_W'(1);
                    r_mem_addr  <= r_blk_start + ADDR_W'(1);
                end else begin
                    r_row_cnt     <= '0;
                    r_blk_cnt     <= '0;
                    r_strip_cnt   <= r_strip_cnt + STR_W'(1);
                    r_strip_start <= r_strip_start + STRIP_STEP;
                    r_blk_start   <= r_strip_start + STRIP_STEP;
                    r_mem_addr    <= r_strip_start + STRIP_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pop_cnt     <= '0;
            r_strip_done  <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_count       <= w_count_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_strip_done <= w_pop && w_last_pop;
            if (w_start_acc) r_pop_cnt <= '0;
            else if (w_pop)  r_pop_cnt <= w_last_pop ? '0 : r_pop_cnt + POP_W'(1);
            r_underflow <= (r_underflow && !w_start_acc) || (i_read_en && w_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= i_mem_rdata;
    end
endmodule

// File: tb/tb_ref_word_fetch.sv
// Bench for ref_word_fetch: in-order memory model with latency/grant control,
// consumer model, and a nested-loop reference for address and data order.
module tb_ref_word_fetch;
    localparam int AW = 20, LS = 4, SW = 2, SR = 3, RS = 2, NS = 2, FD = 8;
    localparam int NW = SW * SR * NS;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, mem_req, strip_done, underflow;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0, read_en = 1'b0;
    logic [63:0]   mem_rdata = '0, ref_data;

    ref_word_fetch #(.ADDR_W(AW), .LINE_STRIDE(LS), .STRIP_WORDS(SW), .STRIP_ROWS(SR),
                     .ROW_STEP(RS), .NUM_STRIPS(NS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base_addr), .o_busy(busy),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_gnt(mem_gnt),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .i_read_en(read_en),
        .o_ref_data(ref_data), .o_strip_done(strip_done), .o_underflow(underflow));

    always #5 clk = ~clk;

    typedef struct { int due; logic [AW-1:0] addr; } rsp_t;
    rsp_t          rsp_q[$];
    logic [AW-1:0] exp_q[$], issued_q[$];
    logic [63:0]   got_q[$];
    int            sd_pos[$];
    int checks = 0, errors = 0;
    int cyc = 0, lat = 1, gnt_pct = 100, rd_mode = 0;
    bit gnt_off = 0, rd_manual = 0, pop_pend = 0, hold_on = 0, busy_prev = 0;
    int fill = 0, pops_done = 0, pops_sched = 0, uf_events = 0, empty_ref_bad = 0;
    int first_pop_cyc = -1, last_pop_cyc = -1, fall_cyc = -1;

    function automatic logic [63:0] word_of(input logic [AW-1:0] a);
        return {a, 12'hCAB, ~a, a[11:0]};
    endfunction

    // Memory and consumer models, both acting on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rsp_q.delete();
                mem_rvalid = 0; mem_gnt = 0; read_en = 0;
                fill = 0; pop_pend = 0; busy_prev = 0;
            end else begin
                if (pop_pend) begin fill--; pops_done++; end
                if (mem_rvalid) fill++;
                pop_pend = 0;
                if (strip_done) sd_pos.push_back(pops_done);
                if (busy_prev && !busy) fall_cyc = cyc;
                busy_prev = busy;
                case (rd_mode)
                    1: read_en = rd_manual;
                    2: read_en = (fill > 0);
                    3: read_en = ($urandom_range(0, 1) == 1);
                    4: begin
                        if (fill >= 4) hold_on = 1;
                        read_en = hold_on && (pops_sched < NW);
                    end
                    default: read_en = 0;
                endcase
                if (read_en) begin
                    if (fill > 0) begin
                        pop_pend = 1;
                        pops_sched++;
                        got_q.push_back(ref_data);
                        if (first_pop_cyc < 0) first_pop_cyc = cyc;
                        last_pop_cyc = cyc;
                    end else begin
                        uf_events++;
                        if (ref_data !== 64'd0) empty_ref_bad++;
                    end
                end
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    mem_rvalid = 1;
                    mem_rdata  = word_of(rsp_q[0].addr);
                    void'(rsp_q.pop_front());
                end else begin
                    mem_rvalid = 0;
                    mem_rdata  = {$urandom, $urandom};
                end
                mem_gnt = !gnt_off && ($urandom_range(1, 100) <= gnt_pct);
                if (mem_req && mem_gnt) begin
                    rsp_t r;
                    r.due = cyc + lat;
                    r.addr = mem_addr;
                    rsp_q.push_back(r);
                    issued_q.push_back(mem_addr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    function automatic int addr_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= issued_q.size() || issued_q[i] !== exp_q[i]) return i;
        return (issued_q.size() == exp_q.size()) ? -1 : exp_q.size();
    endfunction

    function automatic int data_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== word_of(exp_q[i])) return i;
        return (got_q.size() == exp_q.size()) ? -1 : exp_q.size();
    endfunction

    task automatic kick(input logic [AW-1:0] b);
        exp_q.delete();
        for (int s = 0; s < NS; s++)
            for (int bk = 0; bk < SW; bk++)
                for (int r = 0; r < SR; r++)
                    exp_q.push_back(AW'(b + (s * RS + r) * LS + bk));
        issued_q.delete(); got_q.delete(); sd_pos.delete();
        pops_done = 0; pops_sched = 0; uf_events = 0; empty_ref_bad = 0; hold_on = 0;
        first_pop_cyc = -1; last_pop_cyc = -1; fall_cyc = -1;
        base_addr = b; start = 1;
        step();
        start = 0;
    endtask

    task automatic run_to_idle(input int max, input string tag);
        int n = 0;
        while (busy && n < max) begin step(); n++; end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s timeout: busy=1 after %0d cycles, expected 0", tag, max);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) step();
        checks += 6;
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b exp 0", busy); end
        if (mem_req !== 1'b0)    begin errors++; $display("FAIL reset mem_req: got %b exp 0", mem_req); end
        if (mem_addr !== '0)     begin errors++; $display("FAIL reset mem_addr: got %0h exp 0", mem_addr); end
        if (ref_data !== 64'd0)  begin errors++; $display("FAIL reset ref_data: got %0h exp 0", ref_data); end
        if (strip_done !== 1'b0) begin errors++; $display("FAIL reset strip_done: got %b exp 0", strip_done); end
        if (underflow !== 1'b0)  begin errors++; $display("FAIL reset underflow: got %b exp 0", underflow); end
        rst = 0;
        step();
    endtask

    task automatic test_addr_order();
        int d;
        lat = 1; gnt_pct = 100; gnt_off = 0; rd_mode = 2;
        kick(20'd100);
        run_to_idle(300, "addr_order");
        repeat (3) step();
        d = addr_diff();
        checks += 5;
        if (d >= 0) begin errors++; $display("FAIL addr_order: first bad idx %0d, issued %0d exp %0d", d, issued_q.size(), exp_q.size()); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL addr_order mem_req after end: got %b exp 0", mem_req); end
        d = data_diff();
        if (d >= 0) begin errors++; $display("FAIL addr_order data: first bad idx %0d, got %0d words exp %0d", d, got_q.size(), NW); end
        if (!(sd_pos.size() == 2 && sd_pos[0] == NW / 2 && sd_pos[1] == NW)) begin
            errors++; $display("FAIL addr_order strip_done: got %0d pulses exp 2 at pops 6,12", sd_pos.size()); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL addr_order underflow: got %b exp 0", underflow); end
    endtask

    task automatic test_back_to_back();
        int d;
        lat = 3; gnt_pct = 100; gnt_off = 0; rd_mode = 4;
        kick(20'h01234);
        run_to_idle(300, "back_to_back");
        d = data_diff();
        checks += 5;
        if (d >= 0) begin errors++; $display("FAIL b2b data: first bad idx %0d, got %0d words exp %0d", d, got_q.size(), NW); end
        if (uf_events != 0 || underflow !== 1'b0) begin
            errors++; $display("FAIL b2b underflow: events %0d flag %b exp 0/0", uf_events, underflow); end
        if (last_pop_cyc - first_pop_cyc != NW - 1) begin
            errors++; $display("FAIL b2b bubbles: pop span %0d cycles exp %0d", last_pop_cyc - first_pop_cyc, NW - 1); end
        if (!(sd_pos.size() == 2 && sd_pos[0] == NW / 2 && sd_pos[1] == NW)) begin
            errors++; $display("FAIL b2b strip_done: got %0d pulses exp 2", sd_pos.size()); end
        if (fall_cyc != last_pop_cyc + 2) begin
            errors++; $display("FAIL b2b busy fall: cycle %0d exp %0d", fall_cyc, last_pop_cyc + 2); end
        rd_mode = 0;
    endtask

    task automatic test_credit();
        int d;
        lat = 2; gnt_pct = 100; gnt_off = 0; rd_mode = 0;
        kick(AW'($urandom));
        repeat (30) step();
        checks += 2;
        if (issued_q.size() != FD) begin errors++; $display("FAIL credit issued: got %0d exp %0d", issued_q.size(), FD); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL credit mem_req when full: got %b exp 0", mem_req); end
        rd_mode = 1; rd_manual = 1;
        step();
        rd_manual = 0;
        repeat (20) step();
        checks += 2;
        if (issued_q.size() != FD + 1) begin errors++; $display("FAIL credit after pop: issued %0d exp %0d", issued_q.size(), FD + 1); end
        if (!(got_q.size() == 1 && got_q[0] === word_of(exp_q[0]))) begin
            errors++; $display("FAIL credit pop word: got %0d words exp 1 (%0h)", got_q.size(), word_of(exp_q[0])); end
        rd_mode = 2;
        run_to_idle(300, "credit");
        checks += 2;
        d = addr_diff();
        if (d >= 0) begin errors++; $display("FAIL credit addr: first bad idx %0d", d); end
        d = data_diff();
        if (d >= 0) begin errors++; $display("FAIL credit data: first bad idx %0d", d); end
    endtask

    task automatic test_gnt_stall();
        int n = 0, k, d;
        lat = 1; gnt_pct = 100; gnt_off = 0; rd_mode = 2;
        kick(20'h00500);
        while (issued_q.size() < 4 && n < 20) begin step(); n++; end
        gnt_off = 1;
        k = issued_q.size();
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_q[k]) begin
                errors++; $display("FAIL stall cycle %0d: req %b addr %0h exp 1 %0h", c, mem_req, mem_addr, exp_q[k]); end
        end
        gnt_off = 0;
        run_to_idle(300, "stall");
        checks += 2;
        d = addr_diff();
        if (d >= 0) begin errors++; $display("FAIL stall addr: first bad idx %0d, issued %0d exp %0d", d, issued_q.size(), NW); end
        d = data_diff();
        if (d >= 0) begin errors++; $display("FAIL stall data: first bad idx %0d", d); end
    endtask

    task automatic test_underflow();
        lat = 4; gnt_pct = 100; gnt_off = 0; rd_mode = 1; rd_manual = 0;
        kick(20'h00777);
        rd_manual = 1;
        checks++;
        if (ref_data !== 64'd0) begin errors++; $display("FAIL uf ref_data empty: got %0h exp 0", ref_data); end
        step();
        rd_manual = 0;
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf set: got %b exp 1", underflow); end
        rd_mode = 2;
        run_to_idle(300, "underflow");
        checks += 3;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf sticky: got %b exp 1", underflow); end
        if (data_diff() >= 0) begin errors++; $display("FAIL uf data: got %0d words exp %0d", got_q.size(), NW); end
        if (empty_ref_bad != 0) begin errors++; $display("FAIL uf empty ref_data nonzero: %0d times exp 0", empty_ref_bad); end
        kick(20'h00778);
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf clear on start: got %b exp 0", underflow); end
        run_to_idle(300, "underflow2");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lat = 1; gnt_pct = 100; gnt_off = 0; rd_mode = 0;
        kick(20'h00ABC);
        while (fill < 3 && n < 20) begin step(); n++; end
        rst = 1;
        step();
        checks += 6;
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid busy: got %b exp 0", busy); end
        if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mid mem_req: got %b exp 0", mem_req); end
        if (mem_addr !== '0)     begin errors++; $display("FAIL rst_mid mem_addr: got %0h exp 0", mem_addr); end
        if (ref_data !== 64'd0)  begin errors++; $display("FAIL rst_mid ref_data: got %0h exp 0", ref_data); end
        if (strip_done !== 1'b0) begin errors++; $display("FAIL rst_mid strip_done: got %b exp 0", strip_done); end
        if (underflow !== 1'b0)  begin errors++; $display("FAIL rst_mid underflow: got %b exp 0", underflow); end
        rst = 0;
        step();
        rd_mode = 2;
        kick(20'h00ABC);
        run_to_idle(300, "rst_mid");
        checks += 2;
        if (addr_diff() >= 0) begin errors++; $display("FAIL rst_mid restart addr: issued %0d first %0h exp %0h", issued_q.size(), (issued_q.size() > 0) ? issued_q[0] : '0, exp_q[0]); end
        if (data_diff() >= 0) begin errors++; $display("FAIL rst_mid restart data: got %0d words exp %0d", got_q.size(), NW); end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int d;
        for (int it = 0; it < 5; it++) begin
            lat = $urandom_range(1, 6); gnt_pct = $urandom_range(30, 100); gnt_off = 0;
            b = (it == 0) ? 20'hFFFF5 : AW'($urandom);
            rd_mode = 0;
            kick(b);
            rd_mode = 3;
            run_to_idle(3000, "random");
            rd_mode = 0;
            step();
            checks += 5;
            d = addr_diff();
            if (d >= 0) begin errors++; $display("FAIL rand%0d addr: first bad idx %0d base %0h", it, d, b); end
            d = data_diff();
            if (d >= 0) begin errors++; $display("FAIL rand%0d data: first bad idx %0d got %0d words", it, d, got_q.size()); end
            if (!(sd_pos.size() == 2 && sd_pos[0] == NW / 2 && sd_pos[1] == NW)) begin
                errors++; $display("FAIL rand%0d strip_done: got %0d pulses exp 2", it, sd_pos.size()); end
            if (underflow !== (uf_events > 0)) begin
                errors++; $display("FAIL rand%0d underflow: got %b exp %b", it, underflow, uf_events > 0); end
            if (empty_ref_bad != 0) begin
                errors++; $display("FAIL rand%0d empty ref_data nonzero: %0d times exp 0", it, empty_ref_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_addr_order();
        test_back_to_back();
        test_credit();
        test_gnt_stall();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
